// File: rtl/fp_ctrl_pkg.sv
// Shared types and control encodings for the floating-point sequencing controller.
// Opcode values are fixed by the datapath ALUs and must not be renumbered.
package fp_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE, LOAD, EXP, ALIGN, MULT, NORM, ROUND, WRITE
  } state_t;

  localparam logic [3:0] SMALL_SUB      = 4'b0110;
  localparam logic [3:0] SMALL_ADD_BIAS = 4'b0011;
  localparam logic [3:0] BIG_ADD        = 4'b0010;
  localparam logic [3:0] BIG_MUL        = 4'b0100;
  localparam logic [3:0] INC            = 4'b0001;
  localparam logic [3:0] DEC            = 4'b0010;
  localparam logic [7:0] SHIFT_SAT      = 8'd24;

  // Operation context captured in IDLE (op) and LOAD (exponent compare).
  typedef struct packed {
    logic       op;
    logic       expGE;
    logic [7:0] shiftAmt;
  } req_t;

  // |a-b|, clamped so the smaller mantissa is at most fully shifted out.
  function automatic logic [7:0] satShift(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    d = (a >= b) ? (a - b) : (b - a);
    return (d > SHIFT_SAT) ? SHIFT_SAT : d;
  endfunction

endpackage

// File: rtl/fp_ctrl_counter.sv
// Cycle counter shared by the multiply timeout and the renormalisation-pass limit.
// Clear has priority over enable.
module fp_ctrl_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + W'(1);
  end

endmodule

// File: rtl/floating_point_control.sv
// Sequencer for the single-precision datapath: drives every control input for a
// same-sign add or a multiply, reacting to overflow/rounder/multiplier status.
module floating_point_control
  import fp_ctrl_pkg::*;
#(
  parameter int MULT_TIMEOUT = 64,
  parameter int MAX_RENORM   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               op,
  input  logic [7:0]         exp1,
  input  logic [7:0]         exp2,
  input  logic               mantissaOverflow,
  input  logic               endMultiplication,
  input  logic               finalizeOperation,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               controlToMux01,
  output logic               controlToMux02,
  output logic               controlToMux03,
  output logic               controlToMux04,
  output logic               controlToMux05,
  output logic               controlToMux06,
  output logic [7:0]         controlShiftRight,
  output logic signed [22:0] controlShiftLeftOrRight,
  output logic [3:0]         smallALUOperation,
  output logic [3:0]         bigALUOperation,
  output logic [3:0]         controlToIncreaseOrDecrease,
  output logic               muxAControlSmall,
  output logic               muxBControlSmall,
  output logic               loadRegSmall,
  output logic               regSmallALULoad,
  output logic               muxAControl,
  output logic               muxBControl,
  output logic               muxControl,
  output logic               sumOrMultiplication,
  output logic               loadRegA,
  output logic               loadRegB,
  output logic               IncreaseOrDecreaseEnable,
  output logic               loadFinal
);

  localparam int CW = $clog2(MULT_TIMEOUT + 1);

  state_t        state, nextState;
  req_t          req;
  logic          timeoutFlag;
  logic [CW-1:0] count;
  logic          cntClr, cntEn;
  logic          multTimeout, renormOk, renormPass;

  // In MULT the counter holds cycles already spent; elsewhere it counts renorm passes.
  assign multTimeout = (count == CW'(MULT_TIMEOUT - 1));
  assign renormOk    = (count < CW'(MAX_RENORM));
  assign renormPass  = (count != '0);

  assign cntClr = (state == LOAD) || ((state == MULT) && (nextState != MULT));
  assign cntEn  = (state == MULT) || ((state == ROUND) && (nextState == NORM));

  fp_ctrl_counter #(.W(CW)) uCounter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cntClr),
    .en    (cntEn),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req         <= '0;
      timeoutFlag <= 1'b0;
    end else begin
      state <= nextState;
      if ((state == IDLE) && start) req.op <= op;
      if (state == LOAD) begin
        req.expGE    <= (exp1 >= exp2);
        req.shiftAmt <= satShift(exp1, exp2);
      end
      if ((state == MULT) && (nextState == WRITE)) timeoutFlag <= 1'b1;
      else if (state == IDLE)                      timeoutFlag <= 1'b0;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (start) nextState = LOAD;
      LOAD:  nextState = EXP;
      EXP:   nextState = req.op ? MULT : ALIGN;
      ALIGN: nextState = NORM;
      MULT: begin
        if (endMultiplication) nextState = NORM;
        else if (multTimeout)  nextState = WRITE;
      end
      NORM:  nextState = ROUND;
      ROUND: nextState = (finalizeOperation && renormOk) ? NORM : WRITE;
      WRITE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    busy                        = (state != IDLE);
    done                        = 1'b0;
    error                       = 1'b0;
    controlToMux01              = 1'b0;
    controlToMux02              = 1'b0;
    controlToMux03              = 1'b0;
    controlToMux04              = 1'b0;
    controlToMux05              = 1'b0;
    controlToMux06              = 1'b0;
    controlShiftRight           = '0;
    controlShiftLeftOrRight     = '0;
    smallALUOperation           = '0;
    bigALUOperation             = '0;
    controlToIncreaseOrDecrease = '0;
    muxAControlSmall            = 1'b0;
    muxBControlSmall            = 1'b0;
    loadRegSmall                = 1'b0;
    regSmallALULoad             = 1'b0;
    muxAControl                 = 1'b0;
    muxBControl                 = 1'b0;
    muxControl                  = 1'b0;
    sumOrMultiplication         = 1'b0;
    loadRegA                    = 1'b0;
    loadRegB                    = 1'b0;
    IncreaseOrDecreaseEnable    = 1'b0;
    loadFinal                   = 1'b0;
    case (state)
      EXP: begin
        smallALUOperation = req.op ? SMALL_ADD_BIAS : SMALL_SUB;
        loadRegSmall      = 1'b1;
        regSmallALULoad   = 1'b1;
        // Swap small-ALU inputs for add so the subtraction minuend is the larger exponent.
        muxAControlSmall  = !req.op && !req.expGE;
        muxBControlSmall  = !req.op && !req.expGE;
      end
      ALIGN: begin
        controlToMux01      = !req.expGE;
        controlToMux03      = req.expGE;
        controlToMux04      = !req.expGE;
        controlShiftRight   = req.shiftAmt;
        bigALUOperation     = BIG_ADD;
        sumOrMultiplication = 1'b1;
        loadRegA            = 1'b1;
        loadRegB            = 1'b1;
      end
      MULT: begin
        bigALUOperation = BIG_MUL;
        muxAControl     = 1'b1;
        muxBControl     = 1'b1;
        muxControl      = 1'b1;
        loadRegA        = (count == '0);
        loadRegB        = (count == '0);
      end
      NORM: begin
        if (renormPass) begin
          // Rounder carried out: take its result back through and shift right once.
          controlToMux05              = 1'b1;
          controlToMux02              = 1'b1;
          controlShiftLeftOrRight     = '1;
          IncreaseOrDecreaseEnable    = 1'b1;
          controlToIncreaseOrDecrease = INC;
        end else if (mantissaOverflow) begin
          controlShiftLeftOrRight     = '1;
          IncreaseOrDecreaseEnable    = 1'b1;
          controlToIncreaseOrDecrease = INC;
        end else begin
          controlToMux06 = req.op;
        end
      end
      WRITE: begin
        loadFinal = 1'b1;
        done      = 1'b1;
        error     = timeoutFlag;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_floating_point_control.sv
// Scoreboard bench: stimulus queues expected per-operation observations, a monitor
// collects what the controller drove during the operation and compares on done.
module tb_floating_point_control;
  import fp_ctrl_pkg::*;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, op = 1'b0;
  logic [7:0] exp1 = '0, exp2 = '0;
  logic mantissaOverflow = 1'b0, finalizeOperation = 1'b0;
  logic endMultiplication;
  logic busy, done, error;
  logic controlToMux01, controlToMux02, controlToMux03, controlToMux04, controlToMux05, controlToMux06;
  logic [7:0] controlShiftRight;
  logic signed [22:0] controlShiftLeftOrRight;
  logic [3:0] smallALUOperation, bigALUOperation, controlToIncreaseOrDecrease;
  logic muxAControlSmall, muxBControlSmall, loadRegSmall, regSmallALULoad;
  logic muxAControl, muxBControl, muxControl, sumOrMultiplication, loadRegA, loadRegB;
  logic IncreaseOrDecreaseEnable, loadFinal;

  floating_point_control dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .exp1(exp1), .exp2(exp2),
    .mantissaOverflow(mantissaOverflow), .endMultiplication(endMultiplication),
    .finalizeOperation(finalizeOperation), .busy(busy), .done(done), .error(error),
    .controlToMux01(controlToMux01), .controlToMux02(controlToMux02),
    .controlToMux03(controlToMux03), .controlToMux04(controlToMux04),
    .controlToMux05(controlToMux05), .controlToMux06(controlToMux06),
    .controlShiftRight(controlShiftRight), .controlShiftLeftOrRight(controlShiftLeftOrRight),
    .smallALUOperation(smallALUOperation), .bigALUOperation(bigALUOperation),
    .controlToIncreaseOrDecrease(controlToIncreaseOrDecrease),
    .muxAControlSmall(muxAControlSmall), .muxBControlSmall(muxBControlSmall),
    .loadRegSmall(loadRegSmall), .regSmallALULoad(regSmallALULoad),
    .muxAControl(muxAControl), .muxBControl(muxBControl), .muxControl(muxControl),
    .sumOrMultiplication(sumOrMultiplication), .loadRegA(loadRegA), .loadRegB(loadRegB),
    .IncreaseOrDecreaseEnable(IncreaseOrDecreaseEnable), .loadFinal(loadFinal)
  );

  always #5 clk = ~clk;

  // Multiplier model: raise endMultiplication in the endAt-th MULT cycle (0 = never).
  int endAt = 0;
  int mcnt = 0;
  always @(posedge clk) mcnt <= (bigALUOperation == BIG_MUL) ? mcnt + 1 : 0;
  assign endMultiplication = (bigALUOperation == BIG_MUL) && (endAt != 0) && (mcnt == endAt - 1);

  typedef struct {
    int          lat;
    logic        err;
    logic [7:0]  shr;
    logic        m01, m03, m04;
    logic [3:0]  smallOp;
    logic [22:0] normShift;
    int          renorm;
    logic [3:0]  incCode;
  } exp_t;

  exp_t expQ[$];
  exp_t obs;
  int   cyc = 0;
  logic busyD = 1'b0;
  int   checks = 0, errors = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input int lat, input logic err, input logic [7:0] shr,
                              input logic m01, input logic m03, input logic m04,
                              input logic [3:0] smallOp, input logic [22:0] normShift,
                              input int renorm, input logic [3:0] incCode);
    exp_t e;
    e.lat = lat; e.err = err; e.shr = shr; e.m01 = m01; e.m03 = m03; e.m04 = m04;
    e.smallOp = smallOp; e.normShift = normShift; e.renorm = renorm; e.incCode = incCode;
    return e;
  endfunction

  function automatic logic anyOut();
    return |{busy, done, error, controlToMux01, controlToMux02, controlToMux03, controlToMux04,
             controlToMux05, controlToMux06, controlShiftRight, controlShiftLeftOrRight,
             smallALUOperation, bigALUOperation, controlToIncreaseOrDecrease, muxAControlSmall,
             muxBControlSmall, loadRegSmall, regSmallALULoad, muxAControl, muxBControl,
             muxControl, sumOrMultiplication, loadRegA, loadRegB, IncreaseOrDecreaseEnable,
             loadFinal};
  endfunction

  // Monitor: cycle index 1 is LOAD (busy rising edge).
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busyD = 1'b0;
      cyc = 0;
    end else begin
      if (busy && !busyD) begin
        cyc = 1;
        obs = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      end else if (busy) cyc++;
      if (busy) begin
        if (smallALUOperation != 0) obs.smallOp = smallALUOperation;
        if (bigALUOperation == BIG_ADD) begin
          obs.shr = controlShiftRight;
          obs.m01 = controlToMux01;
          obs.m03 = controlToMux03;
          obs.m04 = controlToMux04;
        end
        if (IncreaseOrDecreaseEnable) obs.incCode = controlToIncreaseOrDecrease;
        if (IncreaseOrDecreaseEnable && !controlToMux05) obs.normShift = controlShiftLeftOrRight;
        if (controlToMux05 && controlToMux02) obs.renorm++;
      end
      if (done) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected done: got done=1 expected no operation pending");
        end else begin
          e = expQ.pop_front();
          chk("latency", cyc, e.lat);
          chk("error", error, e.err);
          chk("shiftRight", obs.shr, e.shr);
          chk("mux01", obs.m01, e.m01);
          chk("mux03", obs.m03, e.m03);
          chk("mux04", obs.m04, e.m04);
          chk("smallOp", obs.smallOp, e.smallOp);
          chk("normShift", obs.normShift, e.normShift);
          chk("renormPasses", obs.renorm, e.renorm);
          chk("incCode", obs.incCode, e.incCode);
        end
      end
      busyD = busy;
    end
  end

  task automatic drive(input logic o, input logic [7:0] e1, input logic [7:0] e2,
                       input logic ovf, input logic fin, input int ea);
    @(negedge clk);
    op = o; exp1 = e1; exp2 = e2; mantissaOverflow = ovf; finalizeOperation = fin; endAt = ea;
    start = 1'b1;
  endtask

  task automatic issue(input logic o, input logic [7:0] e1, input logic [7:0] e2,
                       input logic ovf, input logic fin, input int ea);
    drive(o, e1, e2, ovf, fin, ea);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int  n;
    bit  got;
    n = 0;
    got = 0;
    while (!got && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (done) got = 1;
    end
    chk({name, " done seen"}, got, 1);
    if (got) begin
      @(posedge clk); #1;
      chk({name, " done one cycle"}, done, 0);
      chk({name, " busy cleared"}, busy, 0);
    end
  endtask

  initial begin
    bit hit;
    #12;
    chk("reset outputs", anyOut(), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle outputs", anyOut(), 0);

    // 1.5 + 1.5: equal exponents, mantissa sum overflows
    expQ.push_back(mk(6, 0, 0, 0, 1, 0, SMALL_SUB, 23'h7FFFFF, 0, INC));
    issue(0, 8'd127, 8'd127, 1, 0, 0);
    waitDone("add1.5");

    expQ.push_back(mk(6, 0, 3, 0, 1, 0, SMALL_SUB, 0, 0, 0));
    issue(0, 8'd130, 8'd127, 0, 0, 0);
    waitDone("add diff3");

    expQ.push_back(mk(6, 0, 24, 1, 0, 1, SMALL_SUB, 0, 0, 0));
    issue(0, 8'd10, 8'd50, 0, 0, 0);
    waitDone("add diff40");

    expQ.push_back(mk(10, 0, 0, 0, 0, 0, SMALL_ADD_BIAS, 0, 0, 0));
    issue(1, 8'd130, 8'd127, 0, 0, 5);
    waitDone("mul end5");

    expQ.push_back(mk(67, 1, 0, 0, 0, 0, SMALL_ADD_BIAS, 0, 0, 0));
    issue(1, 8'd130, 8'd127, 0, 0, 0);
    waitDone("mul timeout");

    expQ.push_back(mk(10, 0, 0, 0, 1, 0, SMALL_SUB, 0, 2, INC));
    issue(0, 8'd127, 8'd127, 0, 1, 0);
    waitDone("renorm");

    // Asynchronous reset in the middle of ALIGN aborts without a done
    issue(0, 8'd127, 8'd120, 0, 0, 0);
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(posedge clk); #1;
      if (bigALUOperation == BIG_ADD) hit = 1;
    end
    chk("reach align", hit, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset outputs", anyOut(), 0);
    chk("async reset busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;

    expQ.push_back(mk(6, 0, 1, 0, 1, 0, SMALL_SUB, 23'h7FFFFF, 0, INC));
    issue(0, 8'd128, 8'd127, 1, 0, 0);
    waitDone("after reset");

    // start held across WRITE: one IDLE cycle then a second operation
    expQ.push_back(mk(6, 0, 0, 0, 1, 0, SMALL_SUB, 0, 0, 0));
    expQ.push_back(mk(6, 0, 0, 0, 1, 0, SMALL_SUB, 0, 0, 0));
    drive(0, 8'd127, 8'd127, 0, 0, 0);
    waitDone("b2b first");
    @(posedge clk); #1 start = 1'b0;
    chk("b2b restart busy", busy, 1);
    waitDone("b2b second");

    chk("queue drained", expQ.size(), 0);
    #20;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
